// File: rtl/sobel_frame_ctrl.sv
// Frame-buffer read controller feeding window_3x3: streams IMG_W x IMG_H pixels with line/frame blanking.
// Optional macro SOBEL_CTRL_FRAME_LOOP_EN: loop DONE straight back to FRST for continuous streaming.
module sobel_frame_ctrl #(
  parameter int IMG_W   = 320,
  parameter int IMG_H   = 256,
  parameter int H_BLANK = 8,
  parameter int V_BLANK = 16,
  parameter int ADDR_W  = 17
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              hold,
  input  logic [7:0]        pix_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        win_datain,
  output logic              win_datain_en,
  output logic              win_frame_reset,
  output logic              busy,
  output logic              frame_done,
  output logic [9:0]        line_cnt
);

  localparam int PIX_W   = $clog2(IMG_W + 1);
  localparam int BLK_MAX = (H_BLANK > V_BLANK) ? H_BLANK : V_BLANK;
  localparam int BLK_W   = $clog2(BLK_MAX + 1);

  typedef enum logic [2:0] {IDLE, FRST, LINE, HBLK, VBLK, DONE} state_t;

  state_t           state, state_nxt;
  logic [PIX_W-1:0] pix_cnt;
  logic [BLK_W-1:0] blk_cnt;
  logic             line_end, last_line, hblk_end, vblk_end;
  logic             en_nxt, frst_nxt, done_nxt;

  assign win_datain = pix_data;
  assign line_end   = win_datain_en && (pix_cnt == PIX_W'(IMG_W - 1));
  assign last_line  = (line_cnt == 10'(IMG_H - 1));
  assign hblk_end   = (state == HBLK) && (blk_cnt == BLK_W'(H_BLANK - 1));
  assign vblk_end   = (state == VBLK) && (blk_cnt == BLK_W'(V_BLANK - 1));

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = FRST;
      FRST: state_nxt = LINE;
      LINE: if (line_end) state_nxt = last_line ? VBLK : HBLK;
      HBLK: if (hblk_end) state_nxt = LINE;
      VBLK: if (vblk_end) state_nxt = DONE;
`ifdef SOBEL_CTRL_FRAME_LOOP_EN
      DONE: state_nxt = FRST;
`else
      DONE: state_nxt = IDLE;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // Strobes are decoded from the next state so they leave flops aligned with it;
  // hold therefore gates the pixel presented in the following cycle.
  always_comb begin
    en_nxt   = (state_nxt == LINE) && !hold;
    frst_nxt = (state_nxt == FRST);
    done_nxt = (state_nxt == DONE);
    busy     = (state != IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      win_datain_en   <= 1'b0;
      win_frame_reset <= 1'b0;
      frame_done      <= 1'b0;
    end else begin
      win_datain_en   <= en_nxt;
      win_frame_reset <= frst_nxt;
      frame_done      <= done_nxt;
    end
  end

  // Pixel counter runs to IMG_W at line end and is cleared when the line blank finishes.
  always_ff @(posedge clock) begin
    if (reset || state_nxt == FRST) begin
      mem_addr <= '0;
      pix_cnt  <= '0;
      line_cnt <= '0;
    end else if (win_datain_en) begin
      mem_addr <= mem_addr + ADDR_W'(1);
      pix_cnt  <= pix_cnt + PIX_W'(1);
    end else if (hblk_end) begin
      pix_cnt  <= '0;
      line_cnt <= line_cnt + 10'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset)
      blk_cnt <= '0;
    else if ((state == HBLK || state == VBLK) && !hblk_end && !vblk_end)
      blk_cnt <= blk_cnt + BLK_W'(1);
    else
      blk_cnt <= '0;
  end

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Directed bench for sobel_frame_ctrl: small 4x3 instance plus a default-size instance.
module tb_sobel_frame_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Small instance: IMG_W=4, IMG_H=3, H_BLANK=2, V_BLANK=3
  logic       s_reset, s_start, s_hold;
  logic [7:0] s_pix, s_datain;
  logic [3:0] s_addr;
  logic       s_en, s_fr, s_busy, s_done;
  logic [9:0] s_line;

  // Default-size instance
  logic        d_reset, d_start, d_hold;
  logic [7:0]  d_pix, d_datain;
  logic [16:0] d_addr;
  logic        d_en, d_fr, d_busy, d_done;
  logic [9:0]  d_line;

  assign s_pix = {4'h0, s_addr} ^ 8'h5A;
  assign d_pix = d_addr[7:0] ^ 8'hA5;

  sobel_frame_ctrl #(.IMG_W(4), .IMG_H(3), .H_BLANK(2), .V_BLANK(3), .ADDR_W(4)) u_small (
    .clock(clk), .reset(s_reset), .start(s_start), .hold(s_hold), .pix_data(s_pix),
    .mem_addr(s_addr), .win_datain(s_datain), .win_datain_en(s_en),
    .win_frame_reset(s_fr), .busy(s_busy), .frame_done(s_done), .line_cnt(s_line)
  );

  sobel_frame_ctrl u_dflt (
    .clock(clk), .reset(d_reset), .start(d_start), .hold(d_hold), .pix_data(d_pix),
    .mem_addr(d_addr), .win_datain(d_datain), .win_datain_en(d_en),
    .win_frame_reset(d_fr), .busy(d_busy), .frame_done(d_done), .line_cnt(d_line)
  );

  task automatic pulse_small_reset();
    s_reset = 1'b1; s_start = 1'b0; s_hold = 1'b0;
    @(negedge clk);
    s_reset = 1'b0;
  endtask

  task automatic test_reset();
    s_reset = 1'b1; s_start = 1'b0; s_hold = 1'b0;
    d_reset = 1'b1; d_start = 1'b0; d_hold = 1'b0;
    @(negedge clk); @(negedge clk);
    checks++;
    if (s_addr !== 4'd0 || s_line !== 10'd0) begin
      errors++; $display("FAIL reset_small_counters addr=%0d line=%0d required 0/0", s_addr, s_line);
    end
    checks++;
    if ({s_en, s_fr, s_busy, s_done} !== 4'b0000) begin
      errors++; $display("FAIL reset_small_flags en/fr/busy/done=%b required 0000", {s_en, s_fr, s_busy, s_done});
    end
    checks++;
    if ({d_en, d_fr, d_busy, d_done} !== 4'b0000 || d_addr !== 17'd0 || d_line !== 10'd0) begin
      errors++; $display("FAIL reset_dflt flags=%b addr=%0d line=%0d required 0000/0/0",
                         {d_en, d_fr, d_busy, d_done}, d_addr, d_line);
    end
    s_reset = 1'b0; d_reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_small_frame();
    logic exp_en[$];
    logic exp_done[$];
    int   exp_addr[$];
    int   ens = 0;
    for (int l = 0; l < 3; l++) begin
      for (int p = 0; p < 4; p++) begin
        exp_en.push_back(1'b1); exp_done.push_back(1'b0); exp_addr.push_back(l * 4 + p);
      end
      for (int b = 0; b < ((l < 2) ? 2 : 3); b++) begin
        exp_en.push_back(1'b0); exp_done.push_back(1'b0); exp_addr.push_back(-1);
      end
    end
    exp_en.push_back(1'b0); exp_done.push_back(1'b1); exp_addr.push_back(-1);

    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    checks++;
    if (s_fr !== 1'b1 || s_busy !== 1'b1 || s_en !== 1'b0 || s_done !== 1'b0 || s_addr !== 4'd0 || s_line !== 10'd0) begin
      errors++; $display("FAIL small_frst fr=%b busy=%b en=%b done=%b addr=%0d line=%0d required 1 1 0 0 0 0",
                         s_fr, s_busy, s_en, s_done, s_addr, s_line);
    end
    for (int i = 0; i < exp_en.size(); i++) begin
      @(negedge clk);
      if (s_en === 1'b1) ens++;
      checks++;
      if (s_en !== exp_en[i] || s_done !== exp_done[i] || s_fr !== 1'b0 || s_busy !== 1'b1) begin
        errors++; $display("FAIL small_seq[%0d] en=%b done=%b fr=%b busy=%b required en=%b done=%b fr=0 busy=1",
                           i, s_en, s_done, s_fr, s_busy, exp_en[i], exp_done[i]);
      end else if (exp_en[i]) begin
        if (int'(s_addr) != exp_addr[i] || int'(s_line) != exp_addr[i] / 4 ||
            s_datain !== (8'(exp_addr[i]) ^ 8'h5A)) begin
          errors++; $display("FAIL small_addr[%0d] addr=%0d line=%0d data=%h required %0d %0d %h",
                             i, s_addr, s_line, s_datain, exp_addr[i], exp_addr[i] / 4, 8'(exp_addr[i]) ^ 8'h5A);
        end
      end
    end
    checks++;
    if (ens != 12) begin
      errors++; $display("FAIL small_enable_count got=%0d required 12", ens);
    end
    @(negedge clk);
    checks++;
`ifdef SOBEL_CTRL_FRAME_LOOP_EN
    if (s_fr !== 1'b1 || s_busy !== 1'b1) begin
      errors++; $display("FAIL small_loop_restart fr=%b busy=%b required 1 1", s_fr, s_busy);
    end
`else
    if (s_busy !== 1'b0 || s_done !== 1'b0 || s_fr !== 1'b0) begin
      errors++; $display("FAIL small_after_done busy=%b done=%b fr=%b required 0 0 0", s_busy, s_done, s_fr);
    end
`endif
    pulse_small_reset();
  endtask

  task automatic test_start_ignored();
    int dones = 0, frs = 0, ens = 0;
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      s_start = (i == 2 || i == 6) ? 1'b1 : 1'b0;
      if (s_done === 1'b1) dones++;
      if (s_fr === 1'b1) frs++;
      if (s_en === 1'b1) ens++;
    end
    s_start = 1'b0;
    checks++;
    if (dones != 1 || frs != 0 || ens != 12) begin
      errors++; $display("FAIL start_ignored dones=%0d frs=%0d ens=%0d required 1 0 12", dones, frs, ens);
    end
    pulse_small_reset();
  endtask

  task automatic test_reset_mid();
    bit found = 0;
    int dones = 0, busies = 0;
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      if (s_en === 1'b1 && s_addr === 4'd9) found = 1;
    end
    checks++;
    if (!found || s_line !== 10'd2) begin
      errors++; $display("FAIL reset_mid_reach found=%0d line=%0d required 1 2", found, s_line);
    end
    s_reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({s_en, s_fr, s_busy, s_done} !== 4'b0000 || s_addr !== 4'd0 || s_line !== 10'd0) begin
      errors++; $display("FAIL reset_mid_state flags=%b addr=%0d line=%0d required 0000/0/0",
                         {s_en, s_fr, s_busy, s_done}, s_addr, s_line);
    end
    s_reset = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (s_done === 1'b1) dones++;
      if (s_busy === 1'b1) busies++;
    end
    checks++;
    if (dones != 0 || busies != 0) begin
      errors++; $display("FAIL reset_mid_quiet dones=%0d busy_cycles=%0d required 0 0", dones, busies);
    end
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    @(negedge clk);
    checks++;
    if (s_en !== 1'b1 || s_addr !== 4'd0 || s_line !== 10'd0) begin
      errors++; $display("FAIL reset_mid_restart en=%b addr=%0d line=%0d required 1 0 0", s_en, s_addr, s_line);
    end
    pulse_small_reset();
  endtask

  task automatic test_hold();
    bit found = 0, seen_done = 0;
    int ens = 0, bad_data = 0, last = -1;
    d_start = 1'b1;
    @(negedge clk);
    d_start = 1'b0;
    for (int i = 0; i < 3000 && !found; i++) begin
      @(negedge clk);
      if (d_en === 1'b1) begin
        ens++;
        if (d_datain !== (d_addr[7:0] ^ 8'hA5)) bad_data++;
        if (d_addr === 17'd2339) begin found = 1; d_hold = 1'b1; end
      end
    end
    checks++;
    if (!found || d_line !== 10'd7 || ens != 2340) begin
      errors++; $display("FAIL hold_reach found=%0d line=%0d ens=%0d required 1 7 2340", found, d_line, ens);
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (d_en !== 1'b0 || d_addr !== 17'd2340 || d_line !== 10'd7) begin
        errors++; $display("FAIL hold_frozen[%0d] en=%b addr=%0d line=%0d required 0 2340 7", k, d_en, d_addr, d_line);
      end
    end
    d_hold = 1'b0;
    @(negedge clk);
    checks++;
    if (d_en !== 1'b1 || d_addr !== 17'd2340) begin
      errors++; $display("FAIL hold_resume en=%b addr=%0d required 1 2340", d_en, d_addr);
    end
    if (d_en === 1'b1) begin ens++; last = int'(d_addr); end
    for (int i = 0; i < 90000 && !seen_done; i++) begin
      @(negedge clk);
      if (d_en === 1'b1) begin
        ens++; last = int'(d_addr);
        if (d_datain !== (d_addr[7:0] ^ 8'hA5)) bad_data++;
      end
      if (d_done === 1'b1) seen_done = 1;
    end
    checks++;
    if (!seen_done || ens != 81920 || last != 81919) begin
      errors++; $display("FAIL hold_frame done=%0d ens=%0d last_addr=%0d required 1 81920 81919", seen_done, ens, last);
    end
    checks++;
    if (bad_data != 0) begin
      errors++; $display("FAIL hold_datain bad=%0d required 0", bad_data);
    end
    d_reset = 1'b1;
    @(negedge clk);
    d_reset = 1'b0;
  endtask

`ifdef SOBEL_CTRL_FRAME_LOOP_EN
  task automatic test_loop();
    int pos[$];
    int fr_after = 0;
    bit prev_done = 0;
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (prev_done && s_fr === 1'b1) fr_after++;
      prev_done = (s_done === 1'b1);
      if (s_done === 1'b1) pos.push_back(i);
    end
    checks++;
    if (pos.size() != 3) begin
      errors++; $display("FAIL loop_done_count got=%0d required 3", pos.size());
    end else begin
      checks++;
      if (pos[1] - pos[0] != 21 || pos[2] - pos[1] != 21) begin
        errors++; $display("FAIL loop_spacing got=%0d,%0d required 21,21", pos[1] - pos[0], pos[2] - pos[1]);
      end
    end
    checks++;
    if (fr_after != 3) begin
      errors++; $display("FAIL loop_frst_after_done got=%0d required 3", fr_after);
    end
    pulse_small_reset();
  endtask
`endif

  initial begin
    test_reset();
    test_small_frame();
    test_start_ignored();
    test_reset_mid();
`ifdef SOBEL_CTRL_FRAME_LOOP_EN
    test_loop();
`endif
    test_hold();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
